// File: rtl/nibble_serial_add_ctrl_pkg.sv
// Shared types and constants for the nibble-serial add/subtract sequencer.
package nibble_serial_add_ctrl_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Index counter width; a single-nibble build still needs a 1-bit counter.
    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/nibble_serial_add_ctrl_adder.sv
// Shared 4-bit ripple-carry datapath used once per nibble by the sequencer.
module four_bit_parallel_addr
    import nibble_serial_add_ctrl_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] s,
    output logic                cout
);

    logic [NIBBLE_W:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < NIBBLE_W; i++) begin : g_bit
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// Multi-word add/subtract sequencer: one shared 4-bit adder, one nibble per clock,
// carry chained through a register, valid/ready on both request and result sides.
module nibble_serial_add_ctrl
    import nibble_serial_add_ctrl_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start_valid,
    output logic                        start_ready,
    input  logic [NIBBLE_W*NIBBLES-1:0] a,
    input  logic [NIBBLE_W*NIBBLES-1:0] b,
    input  logic                        cin,
    input  logic                        sub,
    output logic                        res_valid,
    input  logic                        res_ready,
    output logic [NIBBLE_W*NIBBLES-1:0] sum,
    output logic                        carry,
    output logic                        overflow,
    output logic                        busy
);

    localparam int W  = NIBBLE_W * NIBBLES;
    localparam int IW = idx_w(NIBBLES);
    localparam logic [IW-1:0] IDX_LAST = IW'(NIBBLES - 1);

    state_e          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    acc_q, acc_d;
    logic            cr_q, cr_d;
    logic [W-1:0]    sum_q, sum_d;
    logic            co_q, co_d;
    logic            ov_q, ov_d;

    logic [NIBBLE_W-1:0] nib_a, nib_b, nib_s;
    logic                nib_co;

    assign nib_a = a_q[int'(idx_q)*NIBBLE_W +: NIBBLE_W];
    assign nib_b = b_q[int'(idx_q)*NIBBLE_W +: NIBBLE_W];

    four_bit_parallel_addr u_adder (
        .a    (nib_a),
        .b    (nib_b),
        .cin  (cr_q),
        .s    (nib_s),
        .cout (nib_co)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        cr_d    = cr_q;
        sum_d   = sum_q;
        co_d    = co_q;
        ov_d    = ov_q;
        case (state_q)
            ST_IDLE: begin
                if (start_valid) begin
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    cr_d    = sub ? 1'b1 : cin;
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                acc_d[int'(idx_q)*NIBBLE_W +: NIBBLE_W] = nib_s;
                cr_d = nib_co;
                if (idx_q == IDX_LAST) begin
                    // Publish the result only at the final edge so outputs stay frozen mid-run.
                    sum_d   = acc_d;
                    co_d    = nib_co;
                    ov_d    = (a_q[W-1] == b_q[W-1]) && (nib_s[NIBBLE_W-1] != a_q[W-1]);
                    idx_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (res_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cr_q    <= 1'b0;
            sum_q   <= '0;
            co_q    <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            cr_q    <= cr_d;
            sum_q   <= sum_d;
            co_q    <= co_d;
            ov_q    <= ov_d;
        end
    end

    assign start_ready = (state_q == ST_IDLE);
    assign res_valid   = (state_q == ST_DONE);
    assign busy        = (state_q != ST_IDLE);
    assign sum         = sum_q;
    assign carry       = co_q;
    assign overflow    = ov_q;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Directed bench for the nibble-serial sequencer: 4-nibble and 1-nibble builds.
module tb_nibble_serial_add_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_valid = 1'b0;
    logic        start_ready;
    logic [15:0] a = '0, b = '0;
    logic        cin = 1'b0, sub = 1'b0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [15:0] sum;
    logic        carry, overflow, busy;

    logic       sv1 = 1'b0, sr1, rv1, rr1 = 1'b0;
    logic [3:0] a1 = '0, b1 = '0, sum1;
    logic       cin1 = 1'b0, sub1 = 1'b0, c1, ov1, busy1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    nibble_serial_add_ctrl #(.NIBBLES(4)) dut (
        .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .res_valid(res_valid), .res_ready(res_ready),
        .sum(sum), .carry(carry), .overflow(overflow), .busy(busy)
    );

    nibble_serial_add_ctrl #(.NIBBLES(1)) dut1 (
        .clk(clk), .rst(rst), .start_valid(sv1), .start_ready(sr1),
        .a(a1), .b(b1), .cin(cin1), .sub(sub1), .res_valid(rv1), .res_ready(rr1),
        .sum(sum1), .carry(c1), .overflow(ov1), .busy(busy1)
    );

    // Drives a request and returns #1 after the handshake edge.
    task automatic send_req(input logic [15:0] ta, input logic [15:0] tb, input logic tc, input logic ts);
        a = ta; b = tb; cin = tc; sub = ts; start_valid = 1'b1;
        @(posedge clk); #1;
        start_valid = 1'b0;
        a = 16'hDEAD; b = 16'hBEEF; cin = ~tc; sub = ~ts;
    endtask

    // Counts edges until res_valid (bounded); reports whether busy stayed high.
    task automatic wait_res(output int lat, output bit busy_ok);
        lat = 0; busy_ok = 1'b1;
        while (!res_valid && lat < 50) begin
            if (!busy) busy_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic take_res();
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (start_ready !== 1'b1 || busy !== 1'b0 || res_valid !== 1'b0) begin
            errors++; $display("FAIL reset_ctrl: sr=%b busy=%b rv=%b want 1 0 0", start_ready, busy, res_valid);
        end
        checks++; if (sum !== 16'h0 || carry !== 1'b0 || overflow !== 1'b0) begin
            errors++; $display("FAIL reset_out: sum=%h c=%b ov=%b want 0 0 0", sum, carry, overflow);
        end
        @(posedge clk); #1; rst = 1'b0; #1;
        checks++; if (start_ready !== 1'b1) begin
            errors++; $display("FAIL reset_release_ready: got %b want 1", start_ready);
        end
    endtask

    task automatic test_add_basic();
        int lat; bit bok;
        send_req(16'h1234, 16'h0FCD, 1'b0, 1'b0);
        checks++; if (start_ready !== 1'b0) begin
            errors++; $display("FAIL add_ready_low: got %b want 0", start_ready);
        end
        wait_res(lat, bok);
        checks++; if (lat != 4) begin
            errors++; $display("FAIL add_latency: got %0d want 4", lat);
        end
        checks++; if (!bok) begin
            errors++; $display("FAIL add_busy: busy dropped during run");
        end
        checks++; if (sum !== 16'h2201 || carry !== 1'b0 || overflow !== 1'b0) begin
            errors++; $display("FAIL add_result: sum=%h c=%b ov=%b want 2201 0 0", sum, carry, overflow);
        end
        take_res();
        checks++; if (res_valid !== 1'b0 || start_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL add_release: rv=%b sr=%b busy=%b want 0 1 0", res_valid, start_ready, busy);
        end
        checks++; if (sum !== 16'h2201) begin
            errors++; $display("FAIL add_hold_idle: sum=%h want 2201", sum);
        end
    endtask

    task automatic test_carry_overflow();
        int lat; bit bok;
        send_req(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        wait_res(lat, bok);
        checks++; if (sum !== 16'h0000 || carry !== 1'b1 || overflow !== 1'b0 || lat != 4) begin
            errors++; $display("FAIL wrap: sum=%h c=%b ov=%b lat=%0d want 0000 1 0 4", sum, carry, overflow, lat);
        end
        take_res();
        send_req(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        wait_res(lat, bok);
        checks++; if (sum !== 16'h8000 || carry !== 1'b0 || overflow !== 1'b1) begin
            errors++; $display("FAIL pos_ovf: sum=%h c=%b ov=%b want 8000 0 1", sum, carry, overflow);
        end
        take_res();
    endtask

    task automatic test_sub();
        int lat; bit bok;
        send_req(16'h0005, 16'h0007, 1'b1, 1'b1);
        wait_res(lat, bok);
        checks++; if (sum !== 16'hFFFE || carry !== 1'b0 || overflow !== 1'b0) begin
            errors++; $display("FAIL sub_borrow: sum=%h c=%b ov=%b want fffe 0 0", sum, carry, overflow);
        end
        take_res();
        send_req(16'h8000, 16'h0001, 1'b0, 1'b1);
        wait_res(lat, bok);
        checks++; if (sum !== 16'h7FFF || carry !== 1'b1 || overflow !== 1'b1) begin
            errors++; $display("FAIL sub_ovf: sum=%h c=%b ov=%b want 7fff 1 1", sum, carry, overflow);
        end
        take_res();
    endtask

    task automatic test_back_to_back();
        int lat; bit bok; int bad;
        send_req(16'h1111, 16'h2222, 1'b0, 1'b0);
        wait_res(lat, bok);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            start_valid = i[0]; a = 16'hFFFF; b = 16'hFFFF;
            @(posedge clk); #1;
            if (sum !== 16'h3333 || carry !== 1'b0 || overflow !== 1'b0 ||
                res_valid !== 1'b1 || start_ready !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin
            errors++; $display("FAIL backpressure_hold: %0d bad cycles want 0 (sum=%h)", bad, sum);
        end
        a = 16'h0100; b = 16'h0200; cin = 1'b1; sub = 1'b0; start_valid = 1'b1;
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        checks++; if (res_valid !== 1'b0 || start_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL b2b_idle: rv=%b sr=%b busy=%b want 0 1 0", res_valid, start_ready, busy);
        end
        @(posedge clk); #1;
        start_valid = 1'b0; a = 16'hDEAD; b = 16'hBEEF; cin = 1'b0;
        checks++; if (busy !== 1'b1 || start_ready !== 1'b0) begin
            errors++; $display("FAIL b2b_accept: busy=%b sr=%b want 1 0", busy, start_ready);
        end
        wait_res(lat, bok);
        checks++; if (sum !== 16'h0301 || carry !== 1'b0 || overflow !== 1'b0 || lat != 4) begin
            errors++; $display("FAIL b2b_result: sum=%h c=%b ov=%b lat=%0d want 0301 0 0 4", sum, carry, overflow, lat);
        end
        take_res();
    endtask

    task automatic test_async_reset();
        int lat; bit bok;
        send_req(16'hAAAA, 16'h5555, 1'b1, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst = 1'b1; #1;
        checks++; if (sum !== 16'h0 || carry !== 1'b0 || overflow !== 1'b0 || res_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL async_rst: sum=%h c=%b ov=%b rv=%b busy=%b want all 0",
                               sum, carry, overflow, res_valid, busy);
        end
        @(posedge clk); #1; rst = 1'b0; #1;
        checks++; if (start_ready !== 1'b1) begin
            errors++; $display("FAIL async_rst_ready: got %b want 1", start_ready);
        end
        send_req(16'h0001, 16'h0001, 1'b0, 1'b0);
        wait_res(lat, bok);
        checks++; if (sum !== 16'h0002 || carry !== 1'b0 || overflow !== 1'b0 || lat != 4) begin
            errors++; $display("FAIL post_rst: sum=%h c=%b ov=%b lat=%0d want 0002 0 0 4", sum, carry, overflow, lat);
        end
        take_res();
    endtask

    task automatic test_n1();
        int lat;
        a1 = 4'hF; b1 = 4'h1; cin1 = 1'b1; sub1 = 1'b0; sv1 = 1'b1;
        @(posedge clk); #1;
        sv1 = 1'b0; a1 = 4'h0; b1 = 4'h0; cin1 = 1'b0;
        lat = 0;
        while (!rv1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++; if (lat != 1) begin
            errors++; $display("FAIL n1_latency: got %0d want 1", lat);
        end
        checks++; if (sum1 !== 4'h1 || c1 !== 1'b1 || ov1 !== 1'b0) begin
            errors++; $display("FAIL n1_result: sum=%h c=%b ov=%b want 1 1 0", sum1, c1, ov1);
        end
        rr1 = 1'b1;
        @(posedge clk); #1;
        rr1 = 1'b0;
        checks++; if (rv1 !== 1'b0 || sr1 !== 1'b1) begin
            errors++; $display("FAIL n1_release: rv=%b sr=%b want 0 1", rv1, sr1);
        end
    endtask

    initial begin
        test_reset();
        test_add_basic();
        test_carry_overflow();
        test_sub();
        test_back_to_back();
        test_async_reset();
        test_n1();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nibble_serial_add_ctrl.md
Name: nibble_serial_add_ctrl

Overview:
Multi-word add/subtract sequencer. It time-shares one 4-bit ripple adder across a wide operand, processing one nibble per clock from LSB to MSB. It chains the carry through a register between cycles. It sits between a requester using a valid/ready request port and a consumer using a valid/ready result port, and trades latency for area against a full-width adder.

Parameters:
NIBBLES, 4, number of 4-bit slices per operand; operand width W = 4*NIBBLES; legal range 1..16

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
start_valid  input  1  request present
start_ready  output  1  block can accept a request (high only in IDLE)
a  input  W  operand A, sampled on request handshake
b  input  W  operand B, sampled on request handshake
cin  input  1  carry-in for add; ignored when sub=1
sub  input  1  0: a+b+cin; 1: a-b
res_valid  output  1  result available
res_ready  input  1  consumer accepts result
sum  output  W  result word
carry  output  1  final carry-out; for sub, 1 = no borrow
overflow  output  1  signed two's-complement overflow
busy  output  1  state != IDLE

Behaviour:
- Reset (async, any time, including mid-RUN):
  - state=IDLE, nibble index=0, operand/result/carry registers=0.
  - Outputs: sum=0, carry=0, overflow=0, res_valid=0, busy=0.
  - start_ready=1 as soon as rst deasserts.
- FSM states are IDLE, RUN and DONE.
  - IDLE: start_ready=1. On start_valid&&start_ready at edge k:
    - Latch a.
    - Latch b_eff = sub ? ~b : b.
    - Load carry_reg = sub ? 1 : cin.
    - Set idx=0 and go to RUN.
  - RUN: one nibble per cycle. Adder inputs are a[4i+3:4i], b_eff[4i+3:4i] and carry_reg.
    - At each edge the sum nibble is written to the result register slice i, carry_reg takes the adder carry-out, and idx increments.
    - When the edge completes idx=NIBBLES-1, the FSM goes to DONE.
  - DONE: res_valid=1; sum, carry and overflow are held stable. On res_valid&&res_ready the FSM returns to IDLE, and res_valid falls at that edge.
- Latency: res_valid rises exactly NIBBLES clock edges after the request-handshake edge. NIBBLES=1 gives 1 cycle.
- No overlap: start_ready=0 in RUN and DONE. A new request is accepted no earlier than the cycle after result handshake.
- start_valid is ignored outside IDLE. Operand input changes after the handshake have no effect.
- Output values:
  - carry = carry_reg after the last nibble.
  - overflow = (a[W-1]==b_eff[W-1]) && (sum[W-1]!=a[W-1]), computed from the latched values.
  - All three outputs are registered and valid only while res_valid=1. Outside DONE they hold the last result, or 0 after reset.
- res_ready while not res_valid has no effect.
- Arithmetic is modulo 2^W; no saturation.

Decomposition:
- Shared package:
  - state enum (IDLE/RUN/DONE)
  - NIBBLE_W=4 constant
  - idx width function clog2(NIBBLES)
- One sub-module: instance of the team's existing four_bit_parallel_addr as the shared 4-bit datapath.
- FSM, index counter, operand/result registers and carry register live in this block.

Test Plan:
- NIBBLES=4, a=0x1234, b=0x0FCD, cin=0, sub=0 -> sum=0x2201, carry=0, overflow=0; res_valid exactly 4 edges after the handshake; busy high for the run.
- a=0xFFFF, b=0x0001, cin=0, sub=0 -> sum=0x0000, carry=1, overflow=0; then a=0x7FFF, b=0x0001 -> sum=0x8000, carry=0, overflow=1.
- sub=1, a=0x0005, b=0x0007, cin=1 (ignored) -> sum=0xFFFE, carry=0, overflow=0; a=0x8000, b=0x0001 -> sum=0x7FFF, carry=1, overflow=1.
- Backpressure: hold res_ready=0 for 10 cycles after res_valid -> sum/carry/overflow stable, start_ready=0, and start_valid pulses are ignored. Raise res_ready -> IDLE next edge; a back-to-back request is accepted the following cycle.
- Assert rst asynchronously (mid-cycle) during RUN at idx=2 -> all outputs 0 immediately, start_ready=1 after release. A fresh request 0x0001+0x0001 -> 0x0002, carry=0, overflow=0.
- NIBBLES=1 build: a=0xF, b=0x1, cin=1 -> sum=0x1, carry=1, latency 1 edge.
